// File: rtl/gemm_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gemm_cmd_scheduler
//  Purpose  : Accepts custom-0 GEMM instructions from the RISC-V core,
//             queues them in a small FIFO and issues them one at a time
//             to the GEMM accelerator. Also provides a FENCE barrier, a
//             completed-command counter and a sticky error flag.
//  Options  : GEMM_TIMEOUT_EN - when defined, a watchdog aborts a command
//             that waits more than TIMEOUT cycles for acc_done.
//  Revision : 1.0 - initial release
// ============================================================================
module gemm_cmd_scheduler #(
  parameter int         DEPTH   = 4,
  parameter logic [6:0] OPCODE  = 7'b0001011,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,               // asynchronous, active-low
  input  logic        gemm_valid,
  input  logic [31:0] gemm_instruction,
  input  logic [31:0] gemm_rdata1,
  input  logic [31:0] gemm_rdata2,
  output logic        gemm_done,
  output logic        acc_start,
  output logic [2:0]  acc_op,
  output logic [31:0] acc_src,
  output logic [31:0] acc_dst,
  input  logic        acc_done,
  output logic        busy,
  output logic [31:0] cmd_count,
  output logic        err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              c_AW       = $clog2(DEPTH);
  localparam int              c_ENTRY_W  = 3 + 32 + 32;
  localparam logic [c_AW:0]   c_PTR_ONE  = {{c_AW{1'b0}}, 1'b1};
  localparam logic [2:0]      c_F3_FENCE = 3'b111;

  // --------------------------------------------------------------------------
  // Issue FSM state encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_AW:0]        r_wr_ptr;
  logic [c_AW:0]        r_rd_ptr;
  logic                 w_full;
  logic                 w_empty;
  logic [c_ENTRY_W-1:0] w_head;

  logic [2:0]           w_funct3;
  logic                 w_opc_ok;
  logic                 w_legal;
  logic                 w_fence;
  logic                 w_illegal;
  logic                 w_req;
  logic                 w_push;
  logic                 w_fence_ok;
  logic                 w_ack;

  logic                 w_pop;
  logic                 w_start;
  logic                 w_complete;
  logic                 w_timeout;

  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_cmd_count;
  logic [2:0]           r_acc_op;
  logic [31:0]          r_acc_src;
  logic [31:0]          r_acc_dst;

  logic                 w_unused_instr;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  assign w_funct3  = gemm_instruction[14:12];
  assign w_opc_ok  = (gemm_instruction[6:0] == OPCODE);
  assign w_legal   = w_opc_ok && (w_funct3[2] == 1'b0);
  assign w_fence   = w_opc_ok && (w_funct3 == c_F3_FENCE);
  assign w_illegal = !w_legal && !w_fence;

  // Only opcode and funct3 carry meaning for this block.
  assign w_unused_instr = ^{gemm_instruction[31:15], gemm_instruction[11:7]};

  // --------------------------------------------------------------------------
  // Core handshake
  // --------------------------------------------------------------------------
  // A request is ignored during the acknowledge cycle, because the core is
  // still holding the operands of the instruction just accepted.
  assign w_req      = gemm_valid && !r_done;
  assign w_push     = w_req && w_legal && !w_full;
  assign w_fence_ok = w_req && w_fence && w_empty && (r_state == S_IDLE);
  assign w_ack      = w_push || (w_req && w_illegal) || w_fence_ok;

  // Acknowledge pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_ack;
      if ((w_req && w_illegal) || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO (extra pointer bit distinguishes full from empty)
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

  // Pointer update; push and pop may happen together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {w_funct3, gemm_rdata1, gemm_rdata2};
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef GEMM_TIMEOUT_EN
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] r_wdog;

  // Watchdog: cleared while entering WAIT, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
`endif

  // Next-state and control decode; acc_done only matters in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef GEMM_TIMEOUT_EN
        else if (r_wdog == c_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Issued command fields, held stable until the next pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_op  <= '0;
      r_acc_src <= '0;
      r_acc_dst <= '0;
    end else if (w_pop) begin
      r_acc_op  <= w_head[c_ENTRY_W-1 -: 3];
      r_acc_src <= w_head[63:32];
      r_acc_dst <= w_head[31:0];
    end
  end

  // Completed-command counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_count <= '0;
    end else if (w_complete) begin
      r_cmd_count <= r_cmd_count + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gemm_done = r_done;
  assign acc_start = w_start;
  assign acc_op    = r_acc_op;
  assign acc_src   = r_acc_src;
  assign acc_dst   = r_acc_dst;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign cmd_count = r_cmd_count;
  assign err       = r_err;

endmodule
`default_nettype wire
